// File: rtl/lane_sync_rx.sv
// lane_sync_rx
//   Per-lane receive sync stage that sits directly after the byte/word aligner.
//   It runs the CGS -> WAIT_ILAS -> ILAS -> DATA link state machine and drives
//   sync_n back upstream; the aligner realigns while sync_n is low. It also
//   captures the ILAS configuration octets, restores /F/ and /A/ replacement
//   characters in user data, and counts link errors.
//   Byte order: byte0 = din[7:0] (earlier in time), byte1 = din[15:8];
//   dk[i] marks byte i as a control character.
//
// Ports
//   clk         in   1    clock
//   rst         in   1    synchronous reset, active-high
//   din         in   16   aligned lane word
//   dk          in   2    K-flags for the din bytes
//   sync_n      out  1    link sync request, low = request CGS
//   dout        out  16   user data with replacement characters restored
//   dout_valid  out  1    dout carries user data (DATA state only)
//   cfg_data    out  112  ILAS config octets 0..13, octet n at [8n+7:8n]
//   cfg_valid   out  1    cfg_data captured and checked
//   link_state  out  2    0=CGS 1=WAIT_ILAS 2=ILAS 3=DATA
//   err_pulse   out  1    one-cycle pulse per cycle with a detected error
//   err_cnt     out  8    errors since rst, saturating at 255
module lane_sync_rx #(
    parameter int MF_WORDS     = 16,
    parameter int ILAS_MF      = 4,
    parameter int CGS_WORDS    = 4,
    parameter int SYNC_MIN     = 8,
    parameter int RESYNC_WORDS = 4,
    parameter int ERR_LIMIT    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  din,
    input  logic [1:0]   dk,
    output logic         sync_n,
    output logic [15:0]  dout,
    output logic         dout_valid,
    output logic [111:0] cfg_data,
    output logic         cfg_valid,
    output logic [1:0]   link_state,
    output logic         err_pulse,
    output logic [7:0]   err_cnt
);

    localparam int WCW = $clog2(MF_WORDS);
    localparam int MFW = $clog2(ILAS_MF);
    localparam int KCW = $clog2(CGS_WORDS + 1);
    localparam int TMW = $clog2(SYNC_MIN + 1);
    localparam int KRW = $clog2(RESYNC_WORDS + 1);
    localparam int DEW = $clog2(ERR_LIMIT + 1);

    localparam logic [WCW-1:0] W_LAST  = WCW'(MF_WORDS - 1);
    localparam logic [MFW-1:0] MF_ONE  = MFW'(1);
    localparam logic [MFW-1:0] MF_LAST = MFW'(ILAS_MF - 1);
    localparam logic [KCW-1:0] KC_DONE = KCW'(CGS_WORDS);
    localparam logic [TMW-1:0] TM_DONE = TMW'(SYNC_MIN);
    localparam logic [KRW-1:0] KR_DONE = KRW'(RESYNC_WORDS);
    localparam logic [DEW-1:0] DE_DONE = DEW'(ERR_LIMIT);

    typedef enum logic [1:0] {
        ST_CGS       = 2'd0,
        ST_WAIT_ILAS = 2'd1,
        ST_ILAS      = 2'd2,
        ST_DATA      = 2'd3
    } state_t;

    state_t         state_r;
    logic           sync_n_r;
    logic [15:0]    dout_r;
    logic           dout_valid_r;
    logic [111:0]   cfg_data_r;
    logic           cfg_valid_r;
    logic           err_pulse_r;
    logic [7:0]     err_cnt_r;
    logic [KCW-1:0] kcnt_r;
    logic [TMW-1:0] tmr_r;
    logic [WCW-1:0] wcnt_r;
    logic [MFW-1:0] mf_r;
    logic [KRW-1:0] kres_r;
    logic [DEW-1:0] derr_r;
    // Previous output word (or last ILAS word as received) used to restore /F/ and /A/
    logic [15:0]    ref_r;

    logic           kword_s;
    logic           rword_s;
    logic           w_first_s;
    logic           w_last_s;
    logic           ok0_s;
    logic           ok1_s;
    logic           ilas_ok_s;
    logic [7:0]     k1_val_s;
    logic [15:0]    data_word_s;
    logic           data_err_s;
    logic [KCW-1:0] kcnt_nxt_s;
    logic [TMW-1:0] tmr_nxt_s;
    logic [WCW-1:0] wcnt_nxt_s;
    logic [KRW-1:0] kres_nxt_s;
    logic [DEW-1:0] derr_nxt_s;
    logic           err_now_s;
    logic           go_cgs_s;

    assign sync_n     = sync_n_r;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign cfg_data   = cfg_data_r;
    assign cfg_valid  = cfg_valid_r;
    assign link_state = state_r;
    assign err_pulse  = err_pulse_r;
    assign err_cnt    = err_cnt_r;

    // Word classification, ILAS legality, DATA replacement and next-count values
    always_comb begin
        kword_s   = (din == 16'hBCBC) && (dk == 2'b11);
        rword_s   = dk[0] && (din[7:0] == 8'h1C);
        w_first_s = (wcnt_r == '0);
        w_last_s  = (wcnt_r == W_LAST);

        // ILAS: /R/ at word 0, /Q/ after it in multiframe 1, /A/ at the last word; no other K bytes
        k1_val_s = w_last_s ? 8'h7C : 8'h9C;
        if (w_first_s) begin
            ok0_s = dk[0] && (din[7:0] == 8'h1C);
        end else begin
            ok0_s = !dk[0];
        end
        if (w_last_s || (w_first_s && (mf_r == MF_ONE))) begin
            ok1_s = dk[1] && (din[15:8] == k1_val_s);
        end else begin
            ok1_s = !dk[1];
        end
        ilas_ok_s = ok0_s && ok1_s;

        // DATA: restore /F/ and /A/ from the previous word, flag illegal control bytes
        data_word_s = din;
        data_err_s  = 1'b0;
        for (int b = 0; b < 2; b++) begin
            if (dk[b]) begin
                case (din[8*b +: 8])
                    8'hFC: data_word_s[8*b +: 8] = ref_r[8*b +: 8];
                    8'h7C: begin
                        data_word_s[8*b +: 8] = ref_r[8*b +: 8];
                        if ((b == 1) && w_last_s) begin
                            data_err_s = data_err_s;
                        end else begin
                            data_err_s = 1'b1;
                        end
                    end
                    8'hBC: data_word_s[8*b +: 8] = din[8*b +: 8];
                    default: data_err_s = 1'b1;
                endcase
            end else begin
                data_word_s[8*b +: 8] = din[8*b +: 8];
            end
        end

        if (!kword_s) begin
            kcnt_nxt_s = '0;
        end else if (kcnt_r == KC_DONE) begin
            kcnt_nxt_s = kcnt_r;
        end else begin
            kcnt_nxt_s = kcnt_r + KCW'(1);
        end

        if (tmr_r == TM_DONE) begin
            tmr_nxt_s = tmr_r;
        end else begin
            tmr_nxt_s = tmr_r + TMW'(1);
        end

        if (w_last_s) begin
            wcnt_nxt_s = '0;
        end else begin
            wcnt_nxt_s = wcnt_r + WCW'(1);
        end

        if (!kword_s) begin
            kres_nxt_s = '0;
        end else if (kres_r == KR_DONE) begin
            kres_nxt_s = kres_r;
        end else begin
            kres_nxt_s = kres_r + KRW'(1);
        end

        if (data_err_s && (derr_r != DE_DONE)) begin
            derr_nxt_s = derr_r + DEW'(1);
        end else begin
            derr_nxt_s = derr_r;
        end

        // Per-state error and return-to-CGS decision
        err_now_s = 1'b0;
        go_cgs_s  = 1'b0;
        case (state_r)
            ST_CGS: begin
                err_now_s = 1'b0;
                go_cgs_s  = 1'b0;
            end
            ST_WAIT_ILAS: begin
                if (kword_s || rword_s) begin
                    err_now_s = 1'b0;
                end else begin
                    err_now_s = 1'b1;
                    go_cgs_s  = 1'b1;
                end
            end
            ST_ILAS: begin
                if (ilas_ok_s) begin
                    err_now_s = 1'b0;
                end else begin
                    err_now_s = 1'b1;
                    go_cgs_s  = 1'b1;
                end
            end
            ST_DATA: begin
                err_now_s = data_err_s;
                go_cgs_s  = (kres_nxt_s == KR_DONE) || (derr_nxt_s == DE_DONE);
            end
            default: begin
                err_now_s = 1'b0;
                go_cgs_s  = 1'b1;
            end
        endcase
    end

    // Link FSM, counters, config capture and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_CGS;
            sync_n_r     <= 1'b0;
            dout_r       <= 16'h0000;
            dout_valid_r <= 1'b0;
            cfg_data_r   <= '0;
            cfg_valid_r  <= 1'b0;
            err_pulse_r  <= 1'b0;
            err_cnt_r    <= 8'h00;
            kcnt_r       <= '0;
            tmr_r        <= '0;
            wcnt_r       <= '0;
            mf_r         <= '0;
            kres_r       <= '0;
            derr_r       <= '0;
            ref_r        <= 16'h0000;
        end else begin
            err_pulse_r <= err_now_s;
            if (err_now_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end

            case (state_r)
                ST_CGS: begin
                    kcnt_r <= kcnt_nxt_s;
                    tmr_r  <= tmr_nxt_s;
                    if ((kcnt_nxt_s == KC_DONE) && (tmr_nxt_s == TM_DONE)) begin
                        state_r  <= ST_WAIT_ILAS;
                        sync_n_r <= 1'b1;
                    end
                end
                ST_WAIT_ILAS: begin
                    // The /R/ word is word 0 of multiframe 0
                    if (rword_s && !kword_s) begin
                        state_r <= ST_ILAS;
                        wcnt_r  <= WCW'(1);
                        mf_r    <= '0;
                        ref_r   <= din;
                    end
                end
                ST_ILAS: begin
                    wcnt_r <= wcnt_nxt_s;
                    ref_r  <= din;
                    if (w_last_s) begin
                        mf_r <= mf_r + MFW'(1);
                    end
                    if (mf_r == MF_ONE) begin
                        for (int i = 0; i < 7; i++) begin
                            if (wcnt_r == WCW'(i + 1)) begin
                                cfg_data_r[16*i +: 16] <= din;
                            end
                        end
                    end
                    if (w_last_s && (mf_r == MF_LAST)) begin
                        state_r     <= ST_DATA;
                        cfg_valid_r <= 1'b1;
                        kres_r      <= '0;
                        derr_r      <= '0;
                    end
                end
                ST_DATA: begin
                    wcnt_r       <= wcnt_nxt_s;
                    kres_r       <= kres_nxt_s;
                    derr_r       <= derr_nxt_s;
                    dout_r       <= data_word_s;
                    dout_valid_r <= 1'b1;
                    ref_r        <= data_word_s;
                end
                default: begin
                    state_r <= ST_CGS;
                end
            endcase

            // Any return to CGS overrides the per-state updates above
            if (go_cgs_s) begin
                state_r      <= ST_CGS;
                sync_n_r     <= 1'b0;
                kcnt_r       <= '0;
                tmr_r        <= '0;
                cfg_valid_r  <= 1'b0;
                dout_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lane_sync_rx.sv
// tb_lane_sync_rx
//   Directed bench for lane_sync_rx. Stimulus pushes the expected data word and
//   error flag into a queue; a forked monitor pops and compares whenever the
//   DUT raises dout_valid. Link-state events are compared directly.
module tb_lane_sync_rx;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  din;
    logic [1:0]   dk;
    logic         sync_n;
    logic [15:0]  dout;
    logic         dout_valid;
    logic [111:0] cfg_data;
    logic         cfg_valid;
    logic [1:0]   link_state;
    logic         err_pulse;
    logic [7:0]   err_cnt;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } exp_t;

    exp_t         sb_q[$];
    int           tests = 0;
    int           fails = 0;
    logic [111:0] exp_cfg;

    lane_sync_rx dut (
        .clk(clk), .rst(rst), .din(din), .dk(dk), .sync_n(sync_n),
        .dout(dout), .dout_valid(dout_valid), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .link_state(link_state),
        .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [111:0] act, input logic [111:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (dout_valid === 1'b1) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_extra: got dout=%h err=%b expected no output", dout, err_pulse);
                end else begin
                    e = sb_q.pop_front();
                    if ({dout, err_pulse} !== {e.d, e.e}) begin
                        fails++;
                        $display("FAIL sb_data: got dout=%h err=%b expected dout=%h err=%b",
                                 dout, err_pulse, e.d, e.e);
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [15:0] w, input logic [1:0] k);
        din = w;
        dk  = k;
        @(posedge clk);
        #1;
    endtask

    task automatic send_exp(input logic [15:0] w, input logic [1:0] k,
                            input logic [15:0] ed, input logic ee);
        exp_t e;
        e.d = ed;
        e.e = ee;
        sb_q.push_back(e);
        send(w, k);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din = 16'h0000;
        dk  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sync_n", sync_n, 0);
        check("rst_dout", dout, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_cfg_data", cfg_data, 0);
        check("rst_cfg_valid", cfg_valid, 0);
        check("rst_link_state", link_state, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
    endtask

    // Full 4x16-word ILAS; bad_mf drops the /A/ flag at word 15 of that multiframe
    task automatic run_ilas(input int bad_mf);
        logic [15:0] w;
        logic [1:0]  k;
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 16; i++) begin
                if (i == 0) begin
                    if (m == 1) begin
                        w = 16'h9C1C; k = 2'b11;
                    end else begin
                        w = {8'(m), 8'h1C}; k = 2'b01;
                    end
                end else if (i == 15) begin
                    w = 16'h7C55; k = (m == bad_mf) ? 2'b00 : 2'b10;
                end else if ((m == 1) && (i <= 7)) begin
                    w = {8'(2*i - 1), 8'(2*i - 2)}; k = 2'b00;
                end else begin
                    w = {8'(m + 64), 8'(i)}; k = 2'b00;
                end
                send(w, k);
                if ((m == 0) && (i == 0)) check("ilas_enter", link_state, 2);
                if ((m == bad_mf) && (i == 15)) return;
            end
        end
    endtask

    task automatic bring_up();
        repeat (8) send(16'hBCBC, 2'b11);
        check("up_wait_ilas", link_state, 1);
        run_ilas(-1);
        check("up_data_state", link_state, 3);
        check("up_cfg_valid", cfg_valid, 1);
    endtask

    initial begin
        fork
            monitor();
        join_none
        for (int n = 0; n < 14; n++) exp_cfg[8*n +: 8] = 8'(n);

        do_reset();

        // 1) CGS: sync_n held low for SYNC_MIN cycles
        for (int i = 0; i < 7; i++) begin
            send(16'hBCBC, 2'b11);
            check("cgs_sync_low", sync_n, 0);
        end
        send(16'hBCBC, 2'b11);
        check("cgs_sync_high", sync_n, 1);
        check("cgs_wait_ilas", link_state, 1);
        send(16'hBCBC, 2'b11);
        check("wait_ilas_stay", link_state, 1);

        // 2) ILAS and config capture
        run_ilas(-1);
        check("ilas_data_state", link_state, 3);
        check("ilas_cfg_valid", cfg_valid, 1);
        check("cfg_octet0", cfg_data[7:0], 8'h00);
        check("cfg_octet13", cfg_data[111:104], 8'h0D);
        check("cfg_all", cfg_data, exp_cfg);
        check("dv_before_data", dout_valid, 0);

        // 3) DATA: /F/ restoration, first word uses last ILAS word as reference
        send_exp(16'hAAFC, 2'b01, 16'hAA55, 1'b0);
        check("dv_first_data", dout_valid, 1);
        send_exp(16'h1234, 2'b00, 16'h1234, 1'b0);
        send_exp(16'hFC34, 2'b10, 16'h1234, 1'b0);
        send_exp(16'h5678, 2'b00, 16'h5678, 1'b0);
        send_exp(16'h9ABC, 2'b00, 16'h9ABC, 1'b0);
        // 4) misplaced /A/ at wcnt 5
        send_exp(16'h7C11, 2'b10, 16'h9A11, 1'b1);
        check("a_err_cnt", err_cnt, 1);
        send_exp(16'h0102, 2'b00, 16'h0102, 1'b0);
        // three /K/ words then a data word: no resync
        for (int i = 0; i < 3; i++) send_exp(16'hBCBC, 2'b11, 16'hBCBC, 1'b0);
        send_exp(16'h0000, 2'b00, 16'h0000, 1'b0);
        for (int i = 11; i < 15; i++) send_exp(16'h2000 + 16'(i), 2'b00, 16'h2000 + 16'(i), 1'b0);
        // legal /A/ at wcnt 15
        send_exp(16'h7C33, 2'b10, 16'h2033, 1'b0);
        check("data_still_up", link_state, 3);
        check("legal_a_err_cnt", err_cnt, 1);

        // 6a) four /K/ words in DATA force CGS without an error
        for (int i = 0; i < 3; i++) send_exp(16'hBCBC, 2'b11, 16'hBCBC, 1'b0);
        send(16'hBCBC, 2'b11);
        check("kres_state", link_state, 0);
        check("kres_sync_n", sync_n, 0);
        check("kres_cfg_valid", cfg_valid, 0);
        check("kres_dout_valid", dout_valid, 0);
        check("kres_no_err", err_pulse, 0);

        // 5) ILAS MF 2 missing /A/
        repeat (8) send(16'hBCBC, 2'b11);
        check("re_wait_ilas", link_state, 1);
        run_ilas(2);
        check("ilas_bad_err", err_pulse, 1);
        check("ilas_bad_state", link_state, 0);
        check("ilas_bad_sync_n", sync_n, 0);
        check("ilas_bad_err_cnt", err_cnt, 2);
        send(16'hBCBC, 2'b11);
        check("err_pulse_single", err_pulse, 0);

        // 6b) eight illegal-K words from a clean reset reach the error limit
        do_reset();
        bring_up();
        for (int i = 0; i < 7; i++) send_exp(16'hF7F7, 2'b11, 16'hF7F7, 1'b1);
        send(16'hF7F7, 2'b11);
        check("elim_state", link_state, 0);
        check("elim_sync_n", sync_n, 0);
        check("elim_cfg_valid", cfg_valid, 0);
        check("elim_err_pulse", err_pulse, 1);
        check("elim_err_cnt", err_cnt, 8);

        // reset in the middle of DATA
        bring_up();
        send_exp(16'h1111, 2'b00, 16'h1111, 1'b0);
        do_reset();

        repeat (3) send(16'h0000, 2'b00);
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
